// File: rtl/capture_ram.sv
// Capture RAM: records a stream of samples into on-chip memory in single-shot or circular mode.
// Optional build macro CAPTURE_RAM_DECIM_EN adds input decimation through port i_decim.
module capture_ram #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_NBIT = 10,
    parameter int RAM_DEPTH     = 2**RAM_ADDR_NBIT
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_mode,
    input  logic                     i_valid,
    input  logic [RAM_WIDTH-1:0]     i_data,
    input  logic                     i_read,
    input  logic [RAM_ADDR_NBIT-1:0] i_addr,
`ifdef CAPTURE_RAM_DECIM_EN
    input  logic [7:0]               i_decim,
`endif
    output logic [RAM_WIDTH-1:0]     o_data,
    output logic                     o_data_valid,
    output logic                     o_busy,
    output logic                     o_mem_done,
    output logic                     o_wrapped,
    output logic [RAM_ADDR_NBIT-1:0] o_wr_ptr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [RAM_ADDR_NBIT-1:0] LAST_C  = RAM_ADDR_NBIT'(RAM_DEPTH - 1);
    localparam logic [RAM_ADDR_NBIT:0]   DEPTH_C = (RAM_ADDR_NBIT + 1)'(RAM_DEPTH);
    localparam logic [RAM_ADDR_NBIT-1:0] ONE_C   = RAM_ADDR_NBIT'(1'b1);

    logic [RAM_WIDTH-1:0]     mem_q [0:RAM_DEPTH-1];

    logic [1:0]               state_q, state_d;
    logic [RAM_ADDR_NBIT-1:0] wr_ptr_q, wr_ptr_d;
    logic                     mem_done_q, mem_done_d;
    logic                     wrapped_q, wrapped_d;
    logic                     busy_q;
    logic [RAM_WIDTH-1:0]     rd_data_q, rd_data_s;
    logic                     rd_valid_q;
    logic                     capture_s;
    logic                     decim_ok_s;
    logic                     store_s;

    assign capture_s = (state_q == ST_CAPTURE);

`ifdef CAPTURE_RAM_DECIM_EN
    logic [7:0] decim_cnt_q, decim_cnt_d;

    // Decimation counter: counts valid samples, a store happens whenever it sits at zero.
    always_comb begin
        decim_cnt_d = decim_cnt_q;
        if ((state_q != ST_CAPTURE) && i_start) begin
            decim_cnt_d = 8'd0;
        end else if (capture_s && i_valid) begin
            decim_cnt_d = (decim_cnt_q == i_decim) ? 8'd0 : decim_cnt_q + 8'd1;
        end else begin
            decim_cnt_d = decim_cnt_q;
        end
    end

    // Decimation counter register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            decim_cnt_q <= 8'd0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
        end
    end

    assign decim_ok_s = (decim_cnt_q == 8'd0);
`else
    assign decim_ok_s = 1'b1;
`endif

    assign store_s = capture_s && i_valid && decim_ok_s;

    // Capture control: state, write pointer and status flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        mem_done_d = mem_done_q;
        wrapped_d  = wrapped_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d    = ST_CAPTURE;
                    wr_ptr_d   = {RAM_ADDR_NBIT{1'b0}};
                    mem_done_d = 1'b0;
                    wrapped_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CAPTURE: begin
                if (store_s) begin
                    if (wr_ptr_q == LAST_C) begin
                        wr_ptr_d = {RAM_ADDR_NBIT{1'b0}};
                        if (i_mode) begin
                            wrapped_d = 1'b1;
                        end else begin
                            state_d    = ST_DONE;
                            mem_done_d = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE_C;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                // Stop wins over continued capture; any same-cycle sample is still stored above.
                if (i_stop) begin
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end else begin
                    mem_done_d = mem_done_d;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wr_ptr_d   = {RAM_ADDR_NBIT{1'b0}};
                mem_done_d = 1'b0;
                wrapped_d  = 1'b0;
            end
        endcase
    end

    // Control registers; busy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {RAM_ADDR_NBIT{1'b0}};
            mem_done_q <= 1'b0;
            wrapped_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_done_q <= mem_done_d;
            wrapped_q  <= wrapped_d;
            busy_q     <= (state_d == ST_CAPTURE);
        end
    end

    // Sample storage; deliberately untouched by reset so a capture survives an abort.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Read mux: addresses beyond the populated depth read as zero.
    always_comb begin
        rd_data_s = {RAM_WIDTH{1'b0}};
        if ({1'b0, i_addr} < DEPTH_C) begin
            rd_data_s = mem_q[i_addr];
        end else begin
            rd_data_s = {RAM_WIDTH{1'b0}};
        end
    end

    // Read port register: one-cycle latency, data held between reads.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q  <= {RAM_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_read;
            if (i_read) begin
                rd_data_q <= rd_data_s;
            end
        end
    end

    assign o_data       = rd_data_q;
    assign o_data_valid = rd_valid_q;
    assign o_busy       = busy_q;
    assign o_mem_done   = mem_done_q;
    assign o_wrapped    = wrapped_q;
    assign o_wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_capture_ram.sv
// Self-checking bench for capture_ram (16 x 16-bit): directed scenarios plus random traffic
// against a sample-list reference model.
module tb_capture_ram;

    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0, i_valid = 1'b0, i_read = 1'b0;
    logic [W-1:0]  i_data = 16'd0;
    logic [N-1:0]  i_addr = 4'd0;
    logic [7:0]    i_decim = 8'd0;
    logic [W-1:0]  o_data;
    logic          o_data_valid, o_busy, o_mem_done, o_wrapped;
    logic [N-1:0]  o_wr_ptr;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_mem [0:D-1];
    int           m_ptr = 0;
    int           m_cnt = 0;
    bit           m_busy = 0, m_done = 0, m_wrap = 0, m_dv = 0;
    logic [W-1:0] m_data = 16'd0;

    capture_ram #(.RAM_WIDTH(W), .RAM_ADDR_NBIT(N), .RAM_DEPTH(D)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_valid(i_valid), .i_data(i_data), .i_read(i_read), .i_addr(i_addr),
`ifdef CAPTURE_RAM_DECIM_EN
        .i_decim(i_decim),
`endif
        .o_data(o_data), .o_data_valid(o_data_valid), .o_busy(o_busy), .o_mem_done(o_mem_done),
        .o_wrapped(o_wrapped), .o_wr_ptr(o_wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".busy"},  {31'd0, o_busy},       {31'd0, m_busy});
        chk({tag, ".done"},  {31'd0, o_mem_done},   {31'd0, m_done});
        chk({tag, ".wrap"},  {31'd0, o_wrapped},    {31'd0, m_wrap});
        chk({tag, ".ptr"},   {28'd0, o_wr_ptr},     m_ptr);
        chk({tag, ".dv"},    {31'd0, o_data_valid}, {31'd0, m_dv});
        chk({tag, ".data"},  {16'd0, o_data},       {16'd0, m_data});
    endtask

    // One clock: apply inputs, advance model by the capture rules, compare after the edge.
    task automatic cyc(input bit st, input bit sp, input bit md, input bit vl,
                       input logic [W-1:0] d, input bit rd, input int a, input string tag);
        i_start = st; i_stop = sp; i_mode = md; i_valid = vl; i_data = d;
        i_read = rd; i_addr = a[N-1:0];
        @(posedge clk);
        m_dv = rd;
        if (rd) m_data = (a < D) ? m_mem[a] : 16'd0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_ptr = 0; m_done = 0; m_wrap = 0; m_cnt = 0;
            end
        end else begin
            if (vl) begin
                if (m_cnt == 0) begin
                    m_mem[m_ptr] = d;
                    m_ptr = (m_ptr + 1) % D;
                    if (m_ptr == 0) begin
                        if (md) m_wrap = 1;
                        else begin m_busy = 0; m_done = 1; end
                    end
                end
                m_cnt = (m_cnt >= int'(i_decim)) ? 0 : m_cnt + 1;
            end
            if (sp) begin m_busy = 0; m_done = 1; end
        end
        #1;
        chk_all(tag);
        @(negedge clk);
    endtask

    task automatic do_read(input int a, input logic [W-1:0] exp, input string tag);
        cyc(0, 0, 0, 0, 16'd0, 1, a, tag);
        chk({tag, ".const"}, {16'd0, o_data}, {16'd0, exp});
    endtask

    initial begin
        // reset state
        #12;
        chk_all("reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        cyc(0, 0, 0, 0, 16'd0, 0, 0, "idle");

        // single-shot fill with 0x100..0x10F
        cyc(1, 0, 0, 0, 16'd0, 0, 0, "ss.start");
        for (int i = 0; i < D; i++) cyc(0, 0, 0, 1, 16'h100 + 16'(i), 0, 0, "ss.fill");
        chk("ss.done_const", {31'd0, o_mem_done}, 32'd1);
        chk("ss.ptr_const", {28'd0, o_wr_ptr}, 32'd0);
        cyc(0, 0, 0, 1, 16'hDEAD, 0, 0, "ss.valid_in_done");
        do_read(5, 16'h105, "ss.rd5");
        do_read(0, 16'h100, "ss.rd0");
        cyc(0, 1, 0, 0, 16'd0, 0, 0, "ss.stop_ignored");

        // circular: 20 samples then stop
        cyc(1, 0, 1, 0, 16'd0, 0, 0, "circ.start");
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 1, 16'(i), 0, 0, "circ.fill");
        cyc(0, 1, 1, 0, 16'd0, 0, 0, "circ.stop");
        chk("circ.wrap_const", {31'd0, o_wrapped}, 32'd1);
        chk("circ.ptr_const", {28'd0, o_wr_ptr}, 32'd4);
        do_read(0, 16'd16, "circ.rd0");
        do_read(4, 16'd4, "circ.rd4");

        // stop together with a valid sample
        cyc(1, 1, 0, 0, 16'd0, 0, 0, "stp.start");
        cyc(0, 0, 0, 1, 16'hA, 0, 0, "stp.a");
        cyc(0, 0, 0, 1, 16'hB, 0, 0, "stp.b");
        cyc(0, 1, 0, 1, 16'hC, 0, 0, "stp.c");
        chk("stp.ptr_const", {28'd0, o_wr_ptr}, 32'd3);
        chk("stp.done_const", {31'd0, o_mem_done}, 32'd1);
        do_read(2, 16'hC, "stp.rd2");

        // same-cycle read and write of one address returns old contents
        cyc(1, 0, 0, 0, 16'd0, 0, 0, "rw.start");
        cyc(0, 0, 0, 1, 16'h5555, 1, 0, "rw.same");
        chk("rw.old_const", {16'd0, o_data}, 32'h0000000A);
        do_read(0, 16'h5555, "rw.new");

        // asynchronous reset mid-capture after 7 samples
        cyc(0, 1, 0, 0, 16'd0, 0, 0, "rst.stop");
        cyc(1, 0, 0, 0, 16'd0, 0, 0, "rst.start");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 16'(i), 1, i, "rst.fill");
        #2;
        i_rst_n = 1'b0;
        #1;
        m_busy = 0; m_done = 0; m_wrap = 0; m_ptr = 0; m_dv = 0; m_data = 16'd0; m_cnt = 0;
        chk_all("rst.async");
        @(negedge clk);
        i_rst_n = 1'b1;
        do_read(6, 16'd6, "rst.rd6");

`ifdef CAPTURE_RAM_DECIM_EN
        i_decim = 8'd2;
        cyc(1, 0, 0, 0, 16'd0, 0, 0, "dec.start");
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 16'(i), 0, 0, "dec.fill");
        chk("dec.ptr_const", {28'd0, o_wr_ptr}, 32'd3);
        do_read(0, 16'd0, "dec.rd0");
        do_read(1, 16'd3, "dec.rd1");
        do_read(2, 16'd6, "dec.rd2");
        cyc(0, 1, 0, 0, 16'd0, 0, 0, "dec.stop");
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
`ifdef CAPTURE_RAM_DECIM_EN
            if (!m_busy) i_decim = 8'($urandom_range(0, 3));
`endif
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) == 0,
                int'($urandom_range(0, D - 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
